// File: rtl/vedic_pkg.sv
// Shared types and constants for the Vedic product accumulator.
package vedic_pkg;

  // Default accumulator width; 12 bits hold 16 x 225 = 3600 without saturating.
  localparam int DEF_ACC_W = 12;
  // Default batch-length field width; a length of 0 encodes 2^DEF_LEN_W products.
  localparam int DEF_LEN_W = 4;
  // Width of one product from the 4x4 multiplier.
  localparam int PROD_W    = 8;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_e;

endpackage

// File: rtl/vedic_sat_add.sv
// Combinational unsigned saturating adder: accumulator plus one 8-bit product.
module vedic_sat_add
  import vedic_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W:0] sum_wide;

  // Add in ACC_W+1 bits; the carry-out marks overflow and forces all-ones.
  always_comb begin
    sum_wide = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    ovf_o    = sum_wide[ACC_W];
    sum_o    = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
  end

endmodule

// File: rtl/vedic_product_accumulator.sv
// Sums a programmable-length batch of multiplier products into a saturating
// accumulator and hands the batch result downstream over valid/ready.
module vedic_product_accumulator
  import vedic_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  input  logic              res_ready
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic               res_ovf_q, res_ovf_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   len_m1;
  logic               accept;
  logic               last_beat;

  vedic_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (prod_data),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  // Handshake qualifiers and batch-length decode; L-1 wraps so length 0 gives 2^LEN_W-1.
  always_comb begin
    prod_ready = (state_q == ACCUM) && ena && !clear;
    accept     = prod_valid && prod_ready;
    len_eff    = (cnt_q == '0) ? acc_len : len_q;
    len_m1     = len_eff - LEN_W'(1);
    last_beat  = accept && (cnt_q == len_m1);
  end

  // Next-state logic: clear beats both handshakes; ena=0 holds everything.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    if (ena) begin
      if (clear) begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        case (state_q)
          ACCUM: begin
            if (accept) begin
              acc_d = add_sum;
              ovf_d = ovf_q | add_ovf;
              if (cnt_q == '0) begin
                len_d = acc_len;
              end
              if (last_beat) begin
                state_d    = OUTPUT;
                cnt_d      = '0;
                res_data_d = add_sum;
                res_ovf_d  = ovf_q | add_ovf;
              end else begin
                cnt_d = cnt_q + LEN_W'(1);
              end
            end
          end
          OUTPUT: begin
            if (res_ready) begin
              state_d = ACCUM;
              acc_d   = '0;
              cnt_d   = '0;
              ovf_d   = 1'b0;
            end
          end
          default: state_d = ACCUM;
        endcase
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so rst_n stays out of the sensitivity list.
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign res_valid = (state_q == OUTPUT);
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;

endmodule
